// File: rtl/iir_biquad.sv
// Direct-form-I biquad with one shared multiplier and a 6-edge sample cycle.
// Define IIR_BIQUAD_SAT_EN to clamp the result instead of wrapping it.
module iir_biquad #(
    parameter int DATA_W = 16,
    parameter int COEF_W = 16,
    parameter int FRAC   = 10,
    parameter int ACC_W  = DATA_W + COEF_W + 3
) (
    input  logic                     CLK,
    input  logic                     RST_N,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] in_data,
    output logic                     out_valid,
    output logic signed [DATA_W-1:0] out_data,
    input  logic                     coef_we,
    input  logic [2:0]               coef_addr,
    input  logic signed [COEF_W-1:0] coef_wdata
);
    localparam int PROD_W = DATA_W + COEF_W;
    localparam logic [COEF_W-1:0] B0_ONE = {{(COEF_W-1){1'b0}}, 1'b1} << FRAC;
    localparam logic [4:0][COEF_W-1:0] COEF_RST = {{(4*COEF_W){1'b0}}, B0_ONE};
    localparam logic signed [ACC_W-1:0] RND = {{(ACC_W-1){1'b0}}, 1'b1} << (FRAC-1);

    typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

    state_t state_q, state_d;
    logic [2:0] term_q, term_d;
    // coef_q is the host-visible bank; act_q is snapshotted at acceptance so
    // writes never disturb a sample already in flight.
    logic [4:0][COEF_W-1:0] coef_q, coef_d, act_q, act_d;
    logic signed [DATA_W-1:0] x0_q, x0_d, x1_q, x1_d, x2_q, x2_d;
    logic signed [DATA_W-1:0] y1_q, y1_d, y2_q, y2_d;
    logic signed [DATA_W-1:0] out_data_q, out_data_d;
    logic out_valid_q, out_valid_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;

    logic signed [DATA_W-1:0] mul_a;
    logic signed [COEF_W-1:0] mul_b;
    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  prod_ext, shifted;
    logic signed [DATA_W-1:0] y_new;

    always_comb begin
        mul_a = '0;
        mul_b = '0;
        case (term_q)
            3'd0: begin mul_a = x0_q; mul_b = $signed(act_q[0]); end
            3'd1: begin mul_a = x1_q; mul_b = $signed(act_q[1]); end
            3'd2: begin mul_a = x2_q; mul_b = $signed(act_q[2]); end
            3'd3: begin mul_a = y1_q; mul_b = $signed(act_q[3]); end
            3'd4: begin mul_a = y2_q; mul_b = $signed(act_q[4]); end
            default: ;
        endcase
        prod     = PROD_W'(mul_a) * PROD_W'(mul_b);
        prod_ext = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
        shifted  = (acc_q + RND) >>> FRAC;
`ifdef IIR_BIQUAD_SAT_EN
        if (shifted > $signed({{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}}))
            y_new = {1'b0, {(DATA_W-1){1'b1}}};
        else if (shifted < $signed({{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}}))
            y_new = {1'b1, {(DATA_W-1){1'b0}}};
        else
            y_new = shifted[DATA_W-1:0];
`else
        y_new = shifted[DATA_W-1:0];
`endif
    end

    always_comb begin
        state_d     = state_q;
        term_d      = term_q;
        coef_d      = coef_q;
        act_d       = act_q;
        x0_d        = x0_q;
        x1_d        = x1_q;
        x2_d        = x2_q;
        y1_d        = y1_q;
        y2_d        = y2_q;
        acc_d       = acc_q;
        out_data_d  = out_data_q;
        out_valid_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (coef_we && coef_addr < 3'd5)
                    coef_d[coef_addr] = coef_wdata;
                if (in_valid) begin
                    x0_d    = in_data;
                    acc_d   = '0;
                    term_d  = '0;
                    act_d   = coef_q;
                    state_d = MAC;
                end
            end
            MAC: begin
                // Feedback terms (a1, a2) are subtracted.
                if (term_q >= 3'd3) acc_d = acc_q - prod_ext;
                else                acc_d = acc_q + prod_ext;
                term_d = term_q + 3'd1;
                if (term_q == 3'd4) state_d = DONE;
            end
            DONE: begin
                out_data_d  = y_new;
                out_valid_d = 1'b1;
                x2_d        = x1_q;
                x1_d        = x0_q;
                y2_d        = y1_q;
                y1_d        = y_new;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= IDLE;
            term_q      <= '0;
            coef_q      <= COEF_RST;
            act_q       <= COEF_RST;
            x0_q        <= '0;
            x1_q        <= '0;
            x2_q        <= '0;
            y1_q        <= '0;
            y2_q        <= '0;
            acc_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            term_q      <= term_d;
            coef_q      <= coef_d;
            act_q       <= act_d;
            x0_q        <= x0_d;
            x1_q        <= x1_d;
            x2_q        <= x2_d;
            y1_q        <= y1_d;
            y2_q        <= y2_d;
            acc_q       <= acc_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
endmodule

// File: tb/tb_iir_biquad.sv
// Directed bench for iir_biquad with hand-computed expectations.
module tb_iir_biquad;
    localparam int DATA_W = 16;
    localparam int COEF_W = 16;

    logic CLK = 1'b0;
    logic RST_N;
    logic in_valid, in_ready, out_valid, coef_we;
    logic signed [DATA_W-1:0] in_data, out_data;
    logic [2:0] coef_addr;
    logic signed [COEF_W-1:0] coef_wdata;

    int checks = 0;
    int errors = 0;

    iir_biquad dut (
        .CLK(CLK), .RST_N(RST_N),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_data(out_data),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wcoef(input logic [2:0] a, input logic signed [COEF_W-1:0] v);
        @(negedge CLK);
        coef_we = 1'b1; coef_addr = a; coef_wdata = v;
        @(posedge CLK); #1;
        coef_we = 1'b0;
    endtask

    // Offers one sample (optionally with a coefficient write on the same edge)
    // and checks latency, value and single-cycle pulse width.
    task automatic feed(input string tag, input int x, input int exp,
                        input logic we, input logic [2:0] a, input logic signed [COEF_W-1:0] v);
        int lat;
        @(negedge CLK);
        chk({tag, " ready"}, in_ready, 1);
        in_valid = 1'b1; in_data = DATA_W'(x);
        coef_we = we; coef_addr = a; coef_wdata = v;
        @(posedge CLK); #1;
        in_valid = 1'b0; coef_we = 1'b0;
        lat = 0;
        do begin
            @(posedge CLK); #1;
            lat++;
        end while (!out_valid && lat < 12);
        chk({tag, " latency"}, lat, 6);
        chk({tag, " data"}, out_data, exp);
        @(posedge CLK); #1;
        chk({tag, " pulse"}, out_valid, 0);
        chk({tag, " hold"}, out_data, exp);
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST_N = 1'b0;
        #1;
        chk("rst out_valid", out_valid, 0);
        chk("rst out_data", out_data, 0);
        chk("rst in_ready", in_ready, 1);
        @(negedge CLK);
        RST_N = 1'b1;
    endtask

    initial begin
        int acc_cnt;
        logic seen;
        RST_N = 1'b1; in_valid = 1'b0; in_data = '0;
        coef_we = 1'b0; coef_addr = '0; coef_wdata = '0;

        // pass-through after reset
        do_reset();
        feed("pass", 1000, 1000, 1'b0, 3'd0, 16'sd0);

        // first-order low-pass: y = 0.5x + 0.5y[n-1]
        do_reset();
        wcoef(3'd0, 16'sd512);
        wcoef(3'd3, -16'sd512);
        feed("lp0", 1024, 512, 1'b0, 3'd0, 16'sd0);
        feed("lp1", 1024, 768, 1'b0, 3'd0, 16'sd0);
        feed("lp2", 1024, 896, 1'b0, 3'd0, 16'sd0);

        // overflow: saturate or wrap
        do_reset();
        wcoef(3'd0, 16'sh7FFF);
`ifdef IIR_BIQUAD_SAT_EN
        feed("ovf", 32767, 32767, 1'b0, 3'd0, 16'sd0);
`else
        feed("ovf", 32767, -64, 1'b0, 3'd0, 16'sd0);
`endif

        // in_valid held through MAC, b0 write during MAC dropped
        do_reset();
        acc_cnt = 0;
        @(negedge CLK);
        in_valid = 1'b1; in_data = 16'sd200;
        for (int k = 0; k < 7; k++) begin
            if (k > 0) @(negedge CLK);
            if (k == 2) begin coef_we = 1'b1; coef_addr = 3'd0; coef_wdata = 16'sh7FFF; end
            if (k == 3) coef_we = 1'b0;
            if (in_ready) acc_cnt++;
            @(posedge CLK);
        end
        @(negedge CLK);
        in_valid = 1'b0;
        chk("held accepts", acc_cnt, 1);
        chk("held out_valid", out_valid, 1);
        chk("held data", out_data, 200);
        feed("mac wr dropped", 100, 100, 1'b0, 3'd0, 16'sd0);

        // same-edge write and acceptance: sample uses old b0
        feed("same edge", 100, 100, 1'b1, 3'd0, 16'sd512);
        feed("new b0", 100, 50, 1'b0, 3'd0, 16'sd0);

        // reset during MAC aborts and clears coefs and history
        do_reset();
        wcoef(3'd0, 16'sd512);
        wcoef(3'd3, -16'sd512);
        feed("pre abort", 1024, 512, 1'b0, 3'd0, 16'sd0);
        @(negedge CLK);
        in_valid = 1'b1; in_data = 16'sd1000;
        @(posedge CLK); #1;
        in_valid = 1'b0;
        @(posedge CLK);
        @(posedge CLK); #2;
        RST_N = 1'b0;
        #1;
        chk("abort in_ready", in_ready, 1);
        chk("abort out_data", out_data, 0);
        @(negedge CLK);
        RST_N = 1'b1;
        #1;
        chk("release in_ready", in_ready, 1);
        seen = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(posedge CLK); #1;
            seen = seen | out_valid;
        end
        chk("abort no out_valid", seen, 0);
        chk("abort out_data idle", out_data, 0);
        feed("post abort", 1000, 1000, 1'b0, 3'd0, 16'sd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
